// File: rtl/serializer_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : serializer_frame_scheduler_if
// Description : Bundle of the scheduler's requester handshake and serializer
//               drive signals.
//               master : the scheduler (drives REQ_READY, PAR_IN, BUSY,
//                        FRAME_START, GRANT_ID)
//               slave  : the environment (drives EN, REQ_VALID, REQ_DATA)
// Ports       : EN          - grant enable
//               REQ_VALID   - per-requester word valid (NUM_REQ)
//               REQ_DATA    - requester i word at [16*i+15:16*i]
//               REQ_READY   - one-hot accept strobe (NUM_REQ)
//               PAR_IN      - word presented to the serializer (16)
//               BUSY        - frame in progress
//               FRAME_START - one-cycle pulse on the first hold cycle
//               GRANT_ID    - index of current / last granted requester
// Revision    : 1.0 - initial release
// ============================================================================
interface serializer_frame_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int c_ID_W = $clog2(NUM_REQ);

  logic                   EN;
  logic [NUM_REQ-1:0]     REQ_VALID;
  logic [16*NUM_REQ-1:0]  REQ_DATA;
  logic [NUM_REQ-1:0]     REQ_READY;
  logic [15:0]            PAR_IN;
  logic                   BUSY;
  logic                   FRAME_START;
  logic [c_ID_W-1:0]      GRANT_ID;

  modport master (
    input  EN,
    input  REQ_VALID,
    input  REQ_DATA,
    output REQ_READY,
    output PAR_IN,
    output BUSY,
    output FRAME_START,
    output GRANT_ID
  );

  modport slave (
    output EN,
    output REQ_VALID,
    output REQ_DATA,
    input  REQ_READY,
    input  PAR_IN,
    input  BUSY,
    input  FRAME_START,
    input  GRANT_ID
  );
endinterface
`default_nettype wire

// File: rtl/serializer_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : serializer_frame_scheduler
// Description : Round-robin scheduler sharing one 16-bit serializer PAR_IN
//               port between NUM_REQ word sources. Each accepted word is held
//               on PAR_IN for HOLD_CYCLES, followed by GAP_CYCLES of zeros.
//               One IDLE cycle between frames is used for arbitration.
// Ports       : CLK   - clock, rising edge
//               RESET - synchronous, active-low reset
//               bus   - serializer_frame_scheduler_if.master (handshake,
//                       PAR_IN, BUSY, FRAME_START, GRANT_ID)
// Revision    : 1.0 - initial release
// ============================================================================
module serializer_frame_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50,
  parameter int GAP_CYCLES  = 7,
  parameter int MSB_FIRST   = 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  serializer_frame_scheduler_if.master  bus
);

  localparam int                c_ID_W      = $clog2(NUM_REQ);
  // One extra bit so pointer + offset cannot overflow before the wrap.
  localparam int                c_IDX_W     = c_ID_W + 1;
  localparam logic [c_ID_W-1:0] c_LAST      = c_ID_W'(NUM_REQ - 1);
  localparam logic [7:0]        c_HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]        c_GAP_LOAD  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [7:0]          r_cnt;
  logic [c_ID_W-1:0]   r_rr_ptr;
  logic [15:0]         r_par_in;
  logic                r_busy;
  logic                r_frame_start;
  logic [c_ID_W-1:0]   r_grant_id;

  logic                w_found;
  logic [c_ID_W-1:0]   w_winner;
  logic [c_IDX_W-1:0]  w_idx;
  logic [15:0]         w_word;
  logic [15:0]         w_cap;
  logic                w_grant;
  logic [NUM_REQ-1:0]  w_ready;
  logic [c_ID_W-1:0]   w_next_ptr;

  // --------------------------------------------------------------------------
  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping
  // explicitly so non-power-of-2 NUM_REQ never selects a missing index.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + c_IDX_W'(k);
      if (w_idx >= c_IDX_W'(NUM_REQ)) begin
        w_idx = w_idx - c_IDX_W'(NUM_REQ);
      end
      if (!w_found && bus.REQ_VALID[w_idx[c_ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[c_ID_W-1:0];
      end
    end
  end

  // A grant only happens in IDLE, with EN high and outside reset. Because the
  // ready strobe only goes to a valid winner, a grant is also the transfer.
  assign w_grant    = RESET && bus.EN && (r_state == ST_IDLE) && w_found;
  assign w_next_ptr = (w_winner == c_LAST) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_ready = '0;
    if (w_grant) begin
      w_ready[w_winner] = 1'b1;
    end
  end

  assign w_word = bus.REQ_DATA[{w_winner, 4'b0000} +: 16];

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      for (genvar gi = 0; gi < 16; gi++) begin : g_rev
        assign w_cap[gi] = w_word[15-gi];
      end
    end else begin : g_lsb_first
      assign w_cap = w_word;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Frame FSM. PAR_IN is registered and is itself the captured word: it is
  // loaded on the grant edge and cleared on the edge that leaves HOLD, so
  // later REQ_DATA changes cannot disturb the current frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_rr_ptr      <= '0;
      r_par_in      <= '0;
      r_busy        <= 1'b0;
      r_frame_start <= 1'b0;
      r_grant_id    <= '0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_par_in      <= w_cap;
            r_grant_id    <= w_winner;
            r_rr_ptr      <= w_next_ptr;
            r_cnt         <= c_HOLD_LOAD;
            r_busy        <= 1'b1;
            r_frame_start <= 1'b1;
            r_state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_cnt == 8'd0) begin
            r_par_in <= '0;
            if (GAP_CYCLES == 0) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt   <= c_GAP_LOAD;
              r_state <= ST_GAP;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == 8'd0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_par_in <= '0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.REQ_READY   = w_ready;
  assign bus.PAR_IN      = r_par_in;
  assign bus.BUSY        = r_busy;
  assign bus.FRAME_START = r_frame_start;
  assign bus.GRANT_ID    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_serializer_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_serializer_frame_scheduler
// Description : Self-checking bench for serializer_frame_scheduler. Unit 0 is
//               the default build (4 req, hold 50, gap 7, reversed); unit 1 is
//               (2 req, hold 1, gap 0, pass-through). A timeline model checks
//               every cycle; directed steps add fixed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serializer_frame_scheduler;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  serializer_frame_scheduler_if #(.NUM_REQ(4)) if_a ();
  serializer_frame_scheduler_if #(.NUM_REQ(2)) if_b ();

  serializer_frame_scheduler #(
    .NUM_REQ(4), .HOLD_CYCLES(50), .GAP_CYCLES(7), .MSB_FIRST(1)
  ) dut_a (.CLK(CLK), .RESET(RESET), .bus(if_a.master));

  serializer_frame_scheduler #(
    .NUM_REQ(2), .HOLD_CYCLES(1), .GAP_CYCLES(0), .MSB_FIRST(0)
  ) dut_b (.CLK(CLK), .RESET(RESET), .bus(if_b.master));

  int checks = 0;
  int errors = 0;

  // Model configuration and state, per unit
  int  n_req [2] = '{4, 2};
  int  hold  [2] = '{50, 1};
  int  gap   [2] = '{7, 0};
  bit  msb   [2] = '{1'b1, 1'b0};
  int  mode  [2];            // 0: drop valid on accept, 1: keep, 2: random refill
  int  m_start [2];          // cycle of the current/last frame's first hold cycle
  logic [15:0] m_word [2];
  int  m_gid [2];
  int  m_ptr [2];
  int  cyc = 0;

  int fs_gid [$];
  int fs_cyc [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rev16(logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  function automatic int qget(int q [$], int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_start[u] = -1000;
      m_word[u]  = '0;
      m_gid[u]   = 0;
      m_ptr[u]   = 0;
    end
  endtask

  // One clock cycle: check the combinational ready strobe, advance the model
  // across the edge, check the registered outputs, then update requesters.
  task automatic tick();
    logic [7:0]  v   [2];
    logic [7:0]  rdy [2];
    logic [7:0]  exp_rdy;
    logic        en  [2];
    logic [15:0] d   [2][4];
    int          win [2];
    int          idx;
    bit          in_hold, in_frame;
    logic [7:0]  obs_busy, obs_fs;
    logic [31:0] obs_par, obs_gid;

    #3;
    v[0] = 8'(if_a.REQ_VALID);  v[1] = 8'(if_b.REQ_VALID);
    rdy[0] = 8'(if_a.REQ_READY); rdy[1] = 8'(if_b.REQ_READY);
    en[0] = if_a.EN;            en[1] = if_b.EN;
    for (int i = 0; i < 4; i++) d[0][i] = if_a.REQ_DATA[16*i +: 16];
    for (int i = 0; i < 2; i++) d[1][i] = if_b.REQ_DATA[16*i +: 16];
    d[1][2] = '0; d[1][3] = '0;

    for (int u = 0; u < 2; u++) begin
      win[u]  = -1;
      exp_rdy = '0;
      if (RESET && en[u] && (cyc >= m_start[u] + hold[u] + gap[u])) begin
        for (int k = 0; k < n_req[u]; k++) begin
          idx = (m_ptr[u] + k) % n_req[u];
          if (win[u] < 0 && v[u][idx]) win[u] = idx;
        end
      end
      if (win[u] >= 0) exp_rdy[win[u]] = 1'b1;
      chk($sformatf("ready u%0d c%0d", u, cyc), 32'(rdy[u]), 32'(exp_rdy));
    end

    @(posedge CLK);
    #1;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (!RESET) begin
        m_start[u] = -1000; m_word[u] = '0; m_gid[u] = 0; m_ptr[u] = 0;
      end else if (win[u] >= 0) begin
        m_start[u] = cyc;
        m_word[u]  = msb[u] ? rev16(d[u][win[u]]) : d[u][win[u]];
        m_gid[u]   = win[u];
        m_ptr[u]   = (win[u] + 1) % n_req[u];
      end
    end

    for (int u = 0; u < 2; u++) begin
      in_hold  = (cyc >= m_start[u]) && (cyc < m_start[u] + hold[u]);
      in_frame = (cyc >= m_start[u]) && (cyc < m_start[u] + hold[u] + gap[u]);
      obs_par  = (u == 0) ? 32'(if_a.PAR_IN)      : 32'(if_b.PAR_IN);
      obs_busy = (u == 0) ? 8'(if_a.BUSY)         : 8'(if_b.BUSY);
      obs_fs   = (u == 0) ? 8'(if_a.FRAME_START)  : 8'(if_b.FRAME_START);
      obs_gid  = (u == 0) ? 32'(if_a.GRANT_ID)    : 32'(if_b.GRANT_ID);
      chk($sformatf("par_in u%0d c%0d", u, cyc), obs_par, in_hold ? 32'(m_word[u]) : 32'h0);
      chk($sformatf("busy u%0d c%0d", u, cyc), 32'(obs_busy), 32'(in_frame));
      chk($sformatf("frame_start u%0d c%0d", u, cyc), 32'(obs_fs), 32'(cyc == m_start[u]));
      chk($sformatf("grant_id u%0d c%0d", u, cyc), obs_gid, 32'(m_gid[u]));
    end

    if (if_a.FRAME_START) begin
      fs_gid.push_back(int'(if_a.GRANT_ID));
      fs_cyc.push_back(cyc);
    end

    // Requester behaviour after the edge
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < n_req[u]; i++) begin
        if (rdy[u][i] && v[u][i]) begin
          if (mode[u] == 0) v[u][i] = 1'b0;
          else if (mode[u] == 2) begin
            v[u][i] = 1'($urandom_range(0, 1));
            d[u][i] = 16'($urandom);
          end
        end else if (mode[u] == 2 && !v[u][i] && $urandom_range(0, 7) == 0) begin
          v[u][i] = 1'b1;
          d[u][i] = 16'($urandom);
        end
      end
    end
    if_a.REQ_VALID = v[0][3:0];
    if_b.REQ_VALID = v[1][1:0];
    for (int i = 0; i < 4; i++) if_a.REQ_DATA[16*i +: 16] = d[0][i];
    for (int i = 0; i < 2; i++) if_b.REQ_DATA[16*i +: 16] = d[1][i];
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  initial begin
    RESET = 1'b0;
    if_a.EN = 1'b0; if_a.REQ_VALID = '0; if_a.REQ_DATA = '0;
    if_b.EN = 1'b0; if_b.REQ_VALID = '0; if_b.REQ_DATA = '0;
    mode[0] = 0; mode[1] = 0;
    model_reset();
    @(posedge CLK);
    #1;

    // Reset state
    ticks(3);
    chk("reset_par", 32'(if_a.PAR_IN), 32'h0);
    chk("reset_busy", 32'(if_a.BUSY), 32'h0);
    RESET = 1'b1;

    // Single word, reversed
    if_a.EN = 1'b1;
    if_a.REQ_DATA[15:0] = 16'hC5AF;
    if_a.REQ_VALID = 4'b0001;
    tick();
    chk("single_par_first", 32'(if_a.PAR_IN), 32'hF5A3);
    chk("single_fs", 32'(if_a.FRAME_START), 32'h1);
    ticks(49);
    chk("single_par_last", 32'(if_a.PAR_IN), 32'hF5A3);
    ticks(1);
    chk("single_gap_first", 32'(if_a.PAR_IN), 32'h0);
    chk("single_gap_busy", 32'(if_a.BUSY), 32'h1);
    ticks(6);
    chk("single_gap_last_busy", 32'(if_a.BUSY), 32'h1);
    ticks(1);
    chk("single_idle_busy", 32'(if_a.BUSY), 32'h0);

    // Fairness: all four valid
    mode[0] = 1;
    do_reset();
    if_a.REQ_DATA = {16'h8888, 16'h4444, 16'h2222, 16'h1111};
    if_a.REQ_VALID = 4'b1111;
    fs_gid.delete(); fs_cyc.delete();
    ticks(240);
    chk("fair_count", 32'(fs_gid.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("fair_gid%0d", i), 32'(qget(fs_gid, i)), 32'(i % 4));
    for (int i = 1; i < 5; i++)
      chk($sformatf("fair_space%0d", i), 32'(qget(fs_cyc, i) - qget(fs_cyc, i - 1)), 32'd58);

    // Wrap with holes: grant 2, then only 0 and 1 valid
    do_reset();
    if_a.REQ_VALID = 4'b0100;
    fs_gid.delete(); fs_cyc.delete();
    tick();
    if_a.REQ_VALID = 4'b0011;
    ticks(120);
    chk("wrap_g0", 32'(qget(fs_gid, 0)), 32'd2);
    chk("wrap_g1", 32'(qget(fs_gid, 1)), 32'd0);
    chk("wrap_g2", 32'(qget(fs_gid, 2)), 32'd1);

    // Reset mid-HOLD
    do_reset();
    if_a.REQ_VALID = 4'b1000;
    tick();
    chk("rst_pre_gid", 32'(if_a.GRANT_ID), 32'd3);
    ticks(19);
    RESET = 1'b0;
    tick();
    chk("rst_par", 32'(if_a.PAR_IN), 32'h0);
    chk("rst_busy", 32'(if_a.BUSY), 32'h0);
    chk("rst_gid", 32'(if_a.GRANT_ID), 32'd0);
    if_a.REQ_VALID = 4'b1110;
    RESET = 1'b1;
    tick();
    chk("rst_after_gid", 32'(if_a.GRANT_ID), 32'd1);
    chk("rst_after_fs", 32'(if_a.FRAME_START), 32'h1);

    // EN gating
    do_reset();
    if_a.REQ_VALID = 4'b1111;
    tick();
    ticks(9);
    if_a.EN = 1'b0;
    ticks(48);
    ticks(20);
    chk("en_idle_busy", 32'(if_a.BUSY), 32'h0);
    chk("en_idle_ready", 32'(if_a.REQ_READY), 32'h0);
    if_a.EN = 1'b1;
    #1;
    chk("en_same_cycle_ready", 32'(if_a.REQ_READY), 32'h2);
    tick();
    chk("en_grant_gid", 32'(if_a.GRANT_ID), 32'd1);
    chk("en_grant_fs", 32'(if_a.FRAME_START), 32'h1);

    // Unit 1: hold 1, gap 0, pass-through, two requesters
    if_a.EN = 1'b0;
    mode[1] = 1;
    if_b.REQ_DATA = {16'h8000, 16'h00F1};
    if_b.REQ_VALID = 2'b11;
    if_b.EN = 1'b1;
    tick();
    chk("b_par0", 32'(if_b.PAR_IN), 32'h00F1);
    chk("b_fs0", 32'(if_b.FRAME_START), 32'h1);
    tick();
    chk("b_idle_par", 32'(if_b.PAR_IN), 32'h0);
    chk("b_idle_busy", 32'(if_b.BUSY), 32'h0);
    tick();
    chk("b_par1", 32'(if_b.PAR_IN), 32'h8000);
    chk("b_fs1", 32'(if_b.FRAME_START), 32'h1);
    ticks(6);

    // Randomized traffic on both units
    mode[0] = 2; mode[1] = 2;
    if_a.EN = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) if_a.EN = ~if_a.EN;
      if ($urandom_range(0, 39) == 0) if_b.EN = ~if_b.EN;
      RESET = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    RESET = 1'b1;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
